// File: rtl/div_issue_ctrl_if.sv
// Operand-in / result-out handshake bundle for div_issue_ctrl.
// The master side offers operand pairs and accepts results; the slave side is the controller.
interface div_issue_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_dividend;
    logic [3:0] in_divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic       out_div_zero;
    logic       out_overflow;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_overflow
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_overflow
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequential wrapper around a combinational 7b/4b divider: operand FIFO, settle-window
// issue FSM, and a held result register with local divide-by-zero / overflow flags.
module div_issue_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    div_issue_ctrl_if.slave    bus,
    output logic [6:0]         div_D,
    output logic [3:0]         div_M,
    input  logic [3:0]         div_Q,
    input  logic [3:0]         div_R,
    output logic               busy,
    output logic [7:0]         result_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW:0]   DEPTH_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [6:0]    r_mem_dividend [FIFO_DEPTH];
    logic [3:0]    r_mem_divisor  [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic [SW-1:0] r_settle;
    logic [6:0]    r_div_d;
    logic [3:0]    r_div_m;

    logic          r_out_valid;
    logic [3:0]    r_quotient;
    logic [3:0]    r_remainder;
    logic          r_div_zero;
    logic          r_overflow;
    logic [7:0]    r_result_count;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;
    logic          w_release;
    logic          w_overflow;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);
    assign w_push  = bus.in_valid && !w_full;

    // The quotient fits in 4 bits only if the top three dividend bits are below the divisor.
    assign w_overflow = ({1'b0, r_div_d[6:4]} >= r_div_m);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_release = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_SETTLE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage carries no reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dividend[r_wr_ptr] <= bus.in_dividend;
            r_mem_divisor[r_wr_ptr]  <= bus.in_divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_d  <= '0;
            r_div_m  <= '0;
            r_settle <= '0;
        end else begin
            if (w_pop) begin
                r_div_d  <= r_mem_dividend[r_rd_ptr];
                r_div_m  <= r_mem_divisor[r_rd_ptr];
                r_settle <= SETTLE_LD;
            end else if (r_state == S_SETTLE && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_div_zero     <= 1'b0;
            r_overflow     <= 1'b0;
            r_result_count <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            if (r_div_m == '0) begin
                r_quotient  <= 4'hF;
                r_remainder <= 4'hF;
                r_div_zero  <= 1'b1;
                r_overflow  <= 1'b0;
            end else begin
                r_quotient  <= div_Q;
                r_remainder <= div_R;
                r_div_zero  <= 1'b0;
                r_overflow  <= w_overflow;
            end
        end else if (w_release) begin
            r_out_valid    <= 1'b0;
            r_result_count <= r_result_count + 1'b1;
        end
    end

    assign bus.in_ready      = !w_full;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_quotient  = r_quotient;
    assign bus.out_remainder = r_remainder;
    assign bus.out_div_zero  = r_div_zero;
    assign bus.out_overflow  = r_overflow;

    assign div_D        = r_div_d;
    assign div_M        = r_div_m;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign result_count = r_result_count;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider on div_D/div_M, arithmetic reference for
// every result, directed scenarios plus a long randomized stream.
module tb_div_issue_ctrl;
    logic       clk;
    logic       rst_n;
    logic [6:0] div_D;
    logic [3:0] div_M;
    logic [3:0] div_Q;
    logic [3:0] div_R;
    logic       busy;
    logic [7:0] result_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int exp_results  = 0;

    localparam int NRAND = 260;
    logic [6:0] ops_a [NRAND];
    logic [3:0] ops_b [NRAND];

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .div_D        (div_D),
        .div_M        (div_M),
        .div_Q        (div_Q),
        .div_R        (div_R),
        .busy         (busy),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational divider standing in for the real one; quotient truncates to 4 bits.
    always_comb begin
        div_Q = '0;
        div_R = '0;
        if (div_M != 0) begin
            div_Q = 4'(div_D / div_M);
            div_R = 4'(div_D % div_M);
        end
    end

    // Expected {quotient, remainder, div_zero, overflow} from plain arithmetic.
    function automatic logic [9:0] ref_result(input int a, input int b);
        int q;
        int r;
        if (b == 0) return {4'hF, 4'hF, 1'b1, 1'b0};
        q = a / b;
        r = a % b;
        return {4'(q), 4'(r), 1'b0, (q > 15)};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.out_quotient, bus.out_remainder, bus.out_div_zero, bus.out_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] a, input logic [3:0] b);
        int w;
        w = 0;
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        while (!bus.in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!bus.in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_dividend = 7'd55;
        bus.in_divisor = 4'd5;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        outs = {bus.out_valid, observed(), div_D, div_M, busy, result_count, 2'b00};
        tests_run++;
        if (outs !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        tests_run++;
        if ({busy, bus.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_push_ignored: busy/out_valid=%b required 00", {busy, bus.out_valid});
        end
        exp_results = 0;
    endtask

    task automatic test_single();
        int lat;
        bus.out_ready = 1'b1;
        push(7'd7, 4'd2);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != 3) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d cycles required 3", lat);
        end
        tests_run++;
        if (observed() !== ref_result(7, 2)) begin
            tests_failed++;
            $display("FAIL single_result: got %h required %h", observed(), ref_result(7, 2));
        end
        tick();
        exp_results++;
        tests_run++;
        if ({bus.out_valid, result_count} !== {1'b0, 8'(exp_results)}) begin
            tests_failed++;
            $display("FAIL single_count: valid/count=%h required %h", {bus.out_valid, result_count}, {1'b0, 8'(exp_results)});
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a [3];
        logic [3:0] b [3];
        int got;
        int w;
        int last_cyc;
        a = '{7'd6, 7'd9, 7'd12};
        b = '{4'd2, 4'd4, 4'd5};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(a[i], b[i]);
        got = 0;
        w = 0;
        last_cyc = 0;
        while (got < 3 && w < 30) begin
            if (bus.out_valid) begin
                tests_run++;
                if (observed() !== ref_result(a[got], b[got])) begin
                    tests_failed++;
                    $display("FAIL b2b_result%0d: got %h required %h", got, observed(), ref_result(a[got], b[got]));
                end
                if (got > 0) begin
                    tests_run++;
                    if (cyc - last_cyc != 3) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles required 3", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            tick();
            w++;
        end
        exp_results += 3;
        tests_run++;
        if (got != 3 || result_count !== 8'(exp_results)) begin
            tests_failed++;
            $display("FAIL b2b_count: results=%0d count=%0d required 3 and %0d", got, result_count, exp_results);
        end
    endtask

    task automatic test_stall();
        logic [6:0] a [5];
        logic [3:0] b [5];
        logic [9:0] snap;
        int got;
        int w;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a[i] = 7'($urandom_range(0, 127));
            b[i] = 4'($urandom_range(1, 15));
        end
        for (int i = 0; i < 5; i++) push(a[i], b[i]);
        tests_run++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL stall_full: in_ready/out_valid=%b required 01", {bus.in_ready, bus.out_valid});
        end
        snap = ref_result(a[0], b[0]);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 7'd99;
        bus.in_divisor  = 4'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.in_ready, bus.out_valid, observed()} !== {2'b01, snap}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got %h required %h", i, {bus.in_ready, bus.out_valid, observed()}, {2'b01, snap});
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        got = 0;
        w = 0;
        while (got < 5 && w < 40) begin
            if (bus.out_valid) begin
                tests_run++;
                if (observed() !== ref_result(a[got], b[got])) begin
                    tests_failed++;
                    $display("FAIL stall_drain%0d: got %h required %h", got, observed(), ref_result(a[got], b[got]));
                end
                got++;
            end
            tick();
            w++;
        end
        repeat (3) tick();
        exp_results += 5;
        tests_run++;
        if ({got, busy, result_count} !== {32'd5, 1'b0, 8'(exp_results)}) begin
            tests_failed++;
            $display("FAIL stall_end: results=%0d busy=%b count=%0d required 5 0 %0d", got, busy, result_count, exp_results);
        end
    endtask

    task automatic test_flags();
        logic [6:0] a [2];
        logic [3:0] b [2];
        logic [9:0] exp_v;
        int w;
        a = '{7'd9, 7'd100};
        b = '{4'd0, 4'd3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(a[i], b[i]);
            w = 0;
            while (!bus.out_valid && w < 20) begin
                tick();
                w++;
            end
            exp_v = ref_result(a[i], b[i]);
            tests_run++;
            if (!bus.out_valid || observed() !== exp_v) begin
                tests_failed++;
                $display("FAIL flags_case%0d: valid=%b got %h required %h", i, bus.out_valid, observed(), exp_v);
            end
            tests_run++;
            if ({bus.out_div_zero, bus.out_overflow} !== (i == 0 ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL flags_bits%0d: dz/ov=%b required %b", i, {bus.out_div_zero, bus.out_overflow}, (i == 0 ? 2'b10 : 2'b01));
            end
            tick();
            exp_results++;
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] outs;
        logic seen_valid;
        bus.out_ready = 1'b1;
        push(7'd20, 4'd3);
        push(7'd40, 4'd7);
        push(7'd60, 4'd11);
        tests_run++;
        if ({busy, bus.out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midrst_pre: busy/out_valid=%b required 10", {busy, bus.out_valid});
        end
        rst_n = 1'b0;
        #1;
        outs = {bus.out_valid, observed(), div_D, div_M, busy, result_count, 1'b0, !bus.in_ready};
        tests_run++;
        if (outs !== 34'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h required 0", outs);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        exp_results = 0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid = seen_valid | bus.out_valid;
        end
        tests_run++;
        if ({seen_valid, busy, result_count} !== 10'd0) begin
            tests_failed++;
            $display("FAIL midrst_stale: valid_seen=%b busy=%b count=%0d required 0 0 0", seen_valid, busy, result_count);
        end
    endtask

    task automatic test_random();
        int sent;
        int got;
        int cycles;
        int bad;
        logic acc;
        logic hs;
        logic [9:0] obs;
        logic [9:0] exp_v;
        for (int i = 0; i < NRAND; i++) begin
            ops_a[i] = 7'($urandom_range(0, 127));
            ops_b[i] = 4'($urandom_range(1, 15));
        end
        bus.out_ready = 1'b1;
        sent = 0;
        got = 0;
        cycles = 0;
        bad = 0;
        while ((sent < NRAND || got < NRAND) && cycles < 3000) begin
            if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                bus.in_valid    = 1'b1;
                bus.in_dividend = ops_a[sent];
                bus.in_divisor  = ops_b[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            obs = observed();
            tick();
            cycles++;
            if (acc) sent++;
            if (hs) begin
                exp_v = ref_result(ops_a[got], ops_b[got]);
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_result%0d: %0d/%0d got %h required %h", got, ops_a[got], ops_b[got], obs, exp_v);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (got != NRAND) begin
            tests_failed++;
            $display("FAIL random_count: got %0d results required %0d", got, NRAND);
        end
        repeat (2) tick();
        tests_run++;
        if (result_count !== 8'd4) begin
            tests_failed++;
            $display("FAIL random_wrap: result_count=%0d required 4", result_count);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b0;
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flags();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
